// File: rtl/kws_frame_scheduler_if.sv
// Handshake bundle between the KWS frame scheduler and its frame source, scoring engine and decision stage.
// master = scheduler side, slave = environment side.
interface kws_frame_scheduler_if #(
  parameter int N_KEYWORDS = 10,
  parameter int N_STATES   = 5
);
  localparam int KW_W = (N_KEYWORDS > 1) ? $clog2(N_KEYWORDS) : 1;
  localparam int ST_W = (N_STATES > 1) ? $clog2(N_STATES) : 1;

  logic            frame_valid;
  logic            frame_last;
  logic            frame_ready;
  logic            eng_req;
  logic [KW_W-1:0] eng_kw;
  logic [ST_W-1:0] eng_state;
  logic            eng_first;
  logic            eng_ack;
  logic            dec_start;
  logic            dec_done;

  modport master (
    input  frame_valid, frame_last, eng_ack, dec_done,
    output frame_ready, eng_req, eng_kw, eng_state, eng_first, dec_start
  );

  modport slave (
    output frame_valid, frame_last, eng_ack, dec_done,
    input  frame_ready, eng_req, eng_kw, eng_state, eng_first, dec_start
  );
endinterface

// File: rtl/kws_frame_scheduler.sv
// Walks the shared HMM scoring engine over every (keyword, state) pair per MFCC frame and triggers
// the keyword decision at end of utterance or frame cap. Optional macro KWS_ABORT_EN adds an abort input.
module kws_frame_scheduler #(
  parameter int N_KEYWORDS = 10,
  parameter int N_STATES   = 5,
  parameter int MAX_FRAMES = 100
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef KWS_ABORT_EN
  input  logic                 abort,
`endif
  kws_frame_scheduler_if.master bus,
  output logic [7:0]           frame_count,
  output logic                 overflow,
  output logic                 busy
);

  localparam int KW_W = (N_KEYWORDS > 1) ? $clog2(N_KEYWORDS) : 1;
  localparam int ST_W = (N_STATES > 1) ? $clog2(N_STATES) : 1;

  localparam logic [KW_W-1:0] KW_LAST = KW_W'(N_KEYWORDS - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(N_STATES - 1);
  localparam logic [7:0]      MAX_CNT = 8'(MAX_FRAMES);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] DECIDE  = 2'd2;
  localparam logic [1:0] WAITDEC = 2'd3;

  logic [1:0]      state;
  logic [KW_W-1:0] kw;
  logic [ST_W-1:0] st;
  logic            last_q;
  logic [7:0]      frame_count_inc;

  always_comb begin
    frame_count_inc = (frame_count == MAX_CNT) ? frame_count : frame_count + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      kw          <= '0;
      st          <= '0;
      last_q      <= 1'b0;
      frame_count <= 8'd0;
      overflow    <= 1'b0;
    end else begin
`ifdef KWS_ABORT_EN
      if (abort) begin
        state       <= IDLE;
        kw          <= '0;
        st          <= '0;
        last_q      <= 1'b0;
        frame_count <= 8'd0;
      end else begin
`endif
      case (state)
        IDLE: begin
          if (bus.frame_valid) begin
            last_q <= bus.frame_last;
            kw     <= '0;
            st     <= '0;
            state  <= RUN;
            if (frame_count == 8'd0) overflow <= 1'b0;
          end
        end
        RUN: begin
          if (bus.eng_ack) begin
            if (st != ST_LAST) begin
              st <= st + 1'b1;
            end else begin
              st <= '0;
              if (kw != KW_LAST) begin
                kw <= kw + 1'b1;
              end else begin
                // Frame complete: decide on last frame or when the cap is reached.
                kw          <= '0;
                frame_count <= frame_count_inc;
                if (last_q) begin
                  state <= DECIDE;
                end else if (frame_count_inc == MAX_CNT) begin
                  overflow <= 1'b1;
                  state    <= DECIDE;
                end else begin
                  state <= IDLE;
                end
              end
            end
          end
        end
        DECIDE: state <= WAITDEC;
        WAITDEC: begin
          if (bus.dec_done) begin
            frame_count <= 8'd0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef KWS_ABORT_EN
      end
`endif
    end
  end

  assign bus.frame_ready = (state == IDLE);
  assign bus.eng_req     = (state == RUN);
  assign bus.eng_kw      = kw;
  assign bus.eng_state   = st;
  assign bus.eng_first   = (state == RUN) && (frame_count == 8'd0);
  assign bus.dec_start   = (state == DECIDE);
  assign busy            = (state != IDLE);

endmodule

// File: tb/tb_kws_frame_scheduler.sv
// Directed self-checking bench for kws_frame_scheduler; a second small instance (MAX_FRAMES=3) covers overflow.
module tb_kws_frame_scheduler;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] frame_count, cap_frame_count;
  logic       overflow, busy, cap_overflow, cap_busy;
`ifdef KWS_ABORT_EN
  logic       abort = 1'b0;
  logic       cap_abort = 1'b0;
`endif
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  kws_frame_scheduler_if #(.N_KEYWORDS(10), .N_STATES(5)) bus ();
  kws_frame_scheduler_if #(.N_KEYWORDS(2), .N_STATES(2)) cap_bus ();

  kws_frame_scheduler #(.N_KEYWORDS(10), .N_STATES(5), .MAX_FRAMES(100)) dut (
    .clk(clk),
    .reset(reset),
`ifdef KWS_ABORT_EN
    .abort(abort),
`endif
    .bus(bus),
    .frame_count(frame_count),
    .overflow(overflow),
    .busy(busy)
  );

  kws_frame_scheduler #(.N_KEYWORDS(2), .N_STATES(2), .MAX_FRAMES(3)) cap_dut (
    .clk(clk),
    .reset(reset),
`ifdef KWS_ABORT_EN
    .abort(cap_abort),
`endif
    .bus(cap_bus),
    .frame_count(cap_frame_count),
    .overflow(cap_overflow),
    .busy(cap_busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.frame_valid = 1'b1;
    bus.frame_last  = 1'b1;
    bus.eng_ack     = 1'b0;
    bus.dec_done    = 1'b0;
    reset = 1'b1;
    repeat (3) tick;
    total++;
    if (busy !== 1'b0 || bus.frame_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_hold_valid: busy=%b ready=%b expected busy=0 ready=1", busy, bus.frame_ready);
    end
    bus.frame_valid = 1'b0;
    bus.frame_last  = 1'b0;
    reset = 1'b0;
    tick;
    total++;
    if ({bus.frame_ready, bus.eng_req, bus.eng_kw, bus.eng_state, bus.eng_first, bus.dec_start,
         frame_count, overflow, busy} !== {1'b1, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL reset_values: ready=%b req=%b kw=%0d st=%0d first=%b dstart=%b cnt=%0d ovf=%b busy=%b expected 1 0 0 0 0 0 0 0 0",
               bus.frame_ready, bus.eng_req, bus.eng_kw, bus.eng_state, bus.eng_first, bus.dec_start,
               frame_count, overflow, busy);
    end
    total++;
    if (cap_busy !== 1'b0 || cap_frame_count !== 8'd0 || cap_overflow !== 1'b0) begin
      bad++;
      $display("[TB] FAIL cap_reset_values: busy=%b cnt=%0d ovf=%b expected 0 0 0", cap_busy, cap_frame_count, cap_overflow);
    end
  endtask

  task automatic test_single_frame;
    int starts;
    starts = 0;
    bus.eng_ack     = 1'b1;
    bus.frame_valid = 1'b1;
    bus.frame_last  = 1'b0;
    tick;
    bus.frame_valid = 1'b0;
    for (int k = 0; k < 50; k++) begin
      total++;
      if (bus.eng_req !== 1'b1 || bus.eng_kw !== 4'(k / 5) || bus.eng_state !== 3'(k % 5) || bus.eng_first !== 1'b1) begin
        bad++;
        $display("[TB] FAIL single_pair%0d: req=%b kw=%0d st=%0d first=%b expected 1 %0d %0d 1",
                 k, bus.eng_req, bus.eng_kw, bus.eng_state, bus.eng_first, k / 5, k % 5);
      end
      if (bus.dec_start === 1'b1) starts++;
      tick;
    end
    total++;
    if (bus.frame_ready !== 1'b1 || busy !== 1'b0 || frame_count !== 8'd1 || starts !== 0) begin
      bad++;
      $display("[TB] FAIL single_done: ready=%b busy=%b cnt=%0d starts=%0d expected 1 0 1 0",
               bus.frame_ready, busy, frame_count, starts);
    end
  endtask

  task automatic test_ack_stall;
    int idx;
    bus.frame_valid = 1'b1;
    tick;
    bus.frame_valid = 1'b0;
    for (int c = 1; c <= 57; c++) begin
      idx = (c <= 18) ? c - 1 : (c <= 25) ? 17 : c - 8;
      bus.eng_ack = !(c >= 18 && c <= 24);
      total++;
      if (bus.eng_req !== 1'b1 || bus.eng_kw !== 4'(idx / 5) || bus.eng_state !== 3'(idx % 5) || bus.eng_first !== 1'b0) begin
        bad++;
        $display("[TB] FAIL stall_cyc%0d: req=%b kw=%0d st=%0d first=%b expected 1 %0d %0d 0",
                 c, bus.eng_req, bus.eng_kw, bus.eng_state, bus.eng_first, idx / 5, idx % 5);
      end
      tick;
    end
    bus.eng_ack = 1'b1;
    total++;
    if (bus.frame_ready !== 1'b1 || frame_count !== 8'd2 || bus.dec_start !== 1'b0) begin
      bad++;
      $display("[TB] FAIL stall_done: ready=%b cnt=%0d dstart=%b expected 1 2 0", bus.frame_ready, frame_count, bus.dec_start);
    end
  endtask

  task automatic test_last_frame;
    int starts;
    starts = 0;
    bus.frame_valid = 1'b1;
    bus.frame_last  = 1'b1;
    tick;
    bus.frame_valid = 1'b0;
    bus.frame_last  = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      total++;
      if (bus.eng_req !== 1'b1 || bus.eng_first !== 1'b0) begin
        bad++;
        $display("[TB] FAIL last_run_cyc%0d: req=%b first=%b expected 1 0", c, bus.eng_req, bus.eng_first);
      end
      if (bus.dec_start === 1'b1) starts++;
      tick;
    end
    total++;
    if (bus.dec_start !== 1'b1 || frame_count !== 8'd3 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL last_decide: dstart=%b cnt=%0d busy=%b expected 1 3 1", bus.dec_start, frame_count, busy);
    end
    for (int c = 51; c <= 54; c++) begin
      if (bus.dec_start === 1'b1) starts++;
      tick;
    end
    total++;
    if (frame_count !== 8'd3 || busy !== 1'b1 || bus.frame_ready !== 1'b0 || bus.dec_start !== 1'b0) begin
      bad++;
      $display("[TB] FAIL last_waitdec: cnt=%0d busy=%b ready=%b dstart=%b expected 3 1 0 0",
               frame_count, busy, bus.frame_ready, bus.dec_start);
    end
    bus.dec_done = 1'b1;
    tick;
    bus.dec_done = 1'b0;
    total++;
    if (bus.frame_ready !== 1'b1 || frame_count !== 8'd0 || busy !== 1'b0 || starts !== 1) begin
      bad++;
      $display("[TB] FAIL last_done: ready=%b cnt=%0d busy=%b starts=%0d expected 1 0 0 1",
               bus.frame_ready, frame_count, busy, starts);
    end
  endtask

  task automatic test_overflow;
    cap_bus.eng_ack  = 1'b1;
    cap_bus.frame_last = 1'b0;
    cap_bus.dec_done = 1'b0;
    for (int f = 1; f <= 3; f++) begin
      cap_bus.frame_valid = 1'b1;
      tick;
      cap_bus.frame_valid = 1'b0;
      total++;
      if (cap_bus.eng_req !== 1'b1 || cap_bus.eng_first !== (f == 1)) begin
        bad++;
        $display("[TB] FAIL cap_first_f%0d: req=%b first=%b expected 1 %b", f, cap_bus.eng_req, cap_bus.eng_first, f == 1);
      end
      repeat (4) tick;
      total++;
      if (f < 3) begin
        if (cap_bus.frame_ready !== 1'b1 || cap_overflow !== 1'b0 || cap_frame_count !== 8'(f) || cap_bus.dec_start !== 1'b0) begin
          bad++;
          $display("[TB] FAIL cap_frame%0d: ready=%b ovf=%b cnt=%0d dstart=%b expected 1 0 %0d 0",
                   f, cap_bus.frame_ready, cap_overflow, cap_frame_count, cap_bus.dec_start, f);
        end
      end else begin
        if (cap_bus.dec_start !== 1'b1 || cap_overflow !== 1'b1 || cap_frame_count !== 8'd3) begin
          bad++;
          $display("[TB] FAIL cap_overflow: dstart=%b ovf=%b cnt=%0d expected 1 1 3",
                   cap_bus.dec_start, cap_overflow, cap_frame_count);
        end
      end
    end
    tick;
    cap_bus.dec_done = 1'b1;
    tick;
    cap_bus.dec_done = 1'b0;
    total++;
    if (cap_bus.frame_ready !== 1'b1 || cap_frame_count !== 8'd0 || cap_overflow !== 1'b1) begin
      bad++;
      $display("[TB] FAIL cap_after_dec: ready=%b cnt=%0d ovf=%b expected 1 0 1", cap_bus.frame_ready, cap_frame_count, cap_overflow);
    end
    cap_bus.frame_valid = 1'b1;
    tick;
    cap_bus.frame_valid = 1'b0;
    total++;
    if (cap_bus.eng_first !== 1'b1 || cap_overflow !== 1'b0) begin
      bad++;
      $display("[TB] FAIL cap_new_utt: first=%b ovf=%b expected 1 0", cap_bus.eng_first, cap_overflow);
    end
    repeat (4) tick;
  endtask

`ifdef KWS_ABORT_EN
  task automatic test_abort;
    int starts;
    starts = 0;
    bus.eng_ack = 1'b1;
    bus.frame_valid = 1'b1;
    tick;
    bus.frame_valid = 1'b0;
    repeat (50) tick;
    total++;
    if (frame_count !== 8'd1) begin
      bad++;
      $display("[TB] FAIL abort_pre_count: cnt=%0d expected 1", frame_count);
    end
    bus.frame_valid = 1'b1;
    bus.frame_last  = 1'b1;
    tick;
    bus.frame_valid = 1'b0;
    bus.frame_last  = 1'b0;
    repeat (26) tick;
    total++;
    if (bus.eng_kw !== 4'd5 || bus.eng_state !== 3'd1) begin
      bad++;
      $display("[TB] FAIL abort_pair: kw=%0d st=%0d expected 5 1", bus.eng_kw, bus.eng_state);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    total++;
    if (bus.frame_ready !== 1'b1 || busy !== 1'b0 || frame_count !== 8'd0 || overflow !== 1'b0) begin
      bad++;
      $display("[TB] FAIL abort_idle: ready=%b busy=%b cnt=%0d ovf=%b expected 1 0 0 0",
               bus.frame_ready, busy, frame_count, overflow);
    end
    for (int c = 0; c < 5; c++) begin
      if (bus.dec_start === 1'b1 || busy === 1'b1) starts++;
      tick;
    end
    total++;
    if (starts !== 0) begin
      bad++;
      $display("[TB] FAIL abort_no_decide: active_cycles=%0d expected 0", starts);
    end
  endtask
`endif

  task automatic test_reset_midrun;
    bus.eng_ack = 1'b1;
    bus.frame_valid = 1'b1;
    tick;
    bus.frame_valid = 1'b0;
    repeat (9) tick;
    total++;
    if (bus.eng_req !== 1'b1 || bus.eng_kw !== 4'd1 || bus.eng_state !== 3'd4) begin
      bad++;
      $display("[TB] FAIL midrun_pre: req=%b kw=%0d st=%0d expected 1 1 4", bus.eng_req, bus.eng_kw, bus.eng_state);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({bus.eng_req, bus.eng_kw, bus.eng_state, bus.eng_first, busy, bus.frame_ready} !== {1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL midrun_async_reset: req=%b kw=%0d st=%0d first=%b busy=%b ready=%b expected 0 0 0 0 0 1",
               bus.eng_req, bus.eng_kw, bus.eng_state, bus.eng_first, busy, bus.frame_ready);
    end
    tick;
    reset = 1'b0;
    tick;
    total++;
    if (bus.frame_ready !== 1'b1 || busy !== 1'b0 || frame_count !== 8'd0) begin
      bad++;
      $display("[TB] FAIL midrun_after: ready=%b busy=%b cnt=%0d expected 1 0 0", bus.frame_ready, busy, frame_count);
    end
  endtask

  initial begin
    cap_bus.frame_valid = 1'b0;
    cap_bus.frame_last  = 1'b0;
    cap_bus.eng_ack     = 1'b0;
    cap_bus.dec_done    = 1'b0;
    test_reset;
    test_single_frame;
    test_ack_stall;
    test_last_frame;
    test_overflow;
`ifdef KWS_ABORT_EN
    test_abort;
`endif
    test_reset_midrun;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kws_frame_scheduler.md
# kws_frame_scheduler

Sequencing controller for the keyword-spotting back end. Accepts one MFCC frame at a time from the feature front end and walks a single shared HMM scoring engine over every (keyword, state) pair for that frame. Tracks frame count within an utterance, and triggers the final keyword decision at end of utterance or when the frame cap is reached. Sits between the MFCC frame source and the time-multiplexed emission/transition scoring datapath plus its decision stage.

## Interface
Parameters:
- N_KEYWORDS, 10, number of keyword HMMs
- N_STATES, 5, states per HMM
- MAX_FRAMES, 100, frame cap per utterance (1..255)

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- frame_valid  in  1  MFCC frame available on the frame bus
- frame_last  in  1  qualifies frame_valid: frame is final frame of utterance
- frame_ready  out  1  scheduler can accept a frame
- eng_req  out  1  scoring request to shared engine
- eng_kw  out  clog2(N_KEYWORDS) (4)  keyword index of current request
- eng_state  out  clog2(N_STATES) (3)  state index of current request
- eng_first  out  1  current frame is first of utterance (engine initialises Viterbi column)
- eng_ack  in  1  engine accepted/completed current pair
- dec_start  out  1  one-cycle pulse: run final keyword decision
- dec_done  in  1  decision stage finished
- frame_count  out  8  frames completed in current utterance
- overflow  out  1  sticky: utterance hit MAX_FRAMES without frame_last
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, RUN, DECIDE, WAITDEC.
- IDLE: frame_ready=1. Frame accept = frame_valid & frame_ready. On accept, latch frame_last into last_q, set kw=0, st=0, go RUN.
- RUN: eng_req=1; eng_kw/eng_state/eng_first held stable until eng_ack is sampled high.
  - On eng_ack: if st<N_STATES-1, st++; else st=0, kw++.
  - Pair order: kw-major, st-minor, i.e. (0,0),(0,1)…(0,N_STATES-1),(1,0)…
  - On eng_ack at pair (N_KEYWORDS-1, N_STATES-1), the frame is complete:
    - frame_count++ (saturating at MAX_FRAMES).
    - If last_q=1, go DECIDE.
    - Else if the new count equals MAX_FRAMES, set overflow=1 and go DECIDE.
    - Otherwise go IDLE.
- DECIDE: dec_start=1 for exactly one cycle, then WAITDEC.
- WAITDEC: wait for dec_done. On dec_done: frame_count=0, go IDLE. overflow stays set until reset or the next accepted frame with frame_count=0.
- eng_first = (frame_count==0) while in RUN; 0 otherwise.
- Ignored inputs:
  - eng_ack outside RUN.
  - dec_done outside WAITDEC.
  - frame_valid outside IDLE (no accept; the source holds the frame).
- Counters are unsigned and wrap-free: kw and st are bounded by the compares above. frame_count never exceeds MAX_FRAMES.

## Timing
- Reset values:
  - frame_ready=1 (state IDLE).
  - eng_req=0, eng_kw=0, eng_state=0, eng_first=0.
  - dec_start=0, frame_count=0, overflow=0, busy=0.
- Accept at edge N: eng_req=1 from cycle N+1.
- With eng_ack tied high, one pair completes per cycle. The last ack is in cycle N+N_KEYWORDS*N_STATES (N+50 at defaults).
- Non-last frame: IDLE (frame_ready=1) at N+51.
- Last frame: dec_start high during cycle N+51, WAITDEC from N+52.
- eng_ack low stalls RUN indefinitely; outputs are held.
- dec_done in the same cycle WAITDEC is entered is honoured; IDLE follows next cycle.
- Reset asserted mid-RUN or in WAITDEC: immediate return to reset values. The in-flight pair is dropped; the engine must tolerate eng_req falling without ack.

## Configuration
- KWS_ABORT_EN defined:
  - Adds input abort (1 bit, synchronous).
  - abort=1 in any state forces IDLE next cycle, clears frame_count and last_q, and suppresses dec_start. overflow is unchanged.
  - abort has priority over eng_ack and dec_done in the same cycle.
- Not defined: no abort port; an utterance ends only via frame_last, MAX_FRAMES, or reset.

## Test plan
- Reset then idle: all outputs at reset values, frame_ready=1, busy=0; frame_valid with reset high is not accepted.
- Single non-last frame, eng_ack tied 1: eng_kw/eng_state sequence 0/0…9/4 over 50 cycles; eng_first=1 throughout; frame_count=1; frame_ready=1 at accept+51; no dec_start.
- Ack stall: eng_ack low for 7 cycles at pair (3,2): eng_kw=3, eng_state=2 held; frame completes 7 cycles later than unstalled.
- Three frames with frame_last on the third: eng_first=0 on frames 2–3; dec_start pulses once at accept3+51; dec_done 4 cycles later → frame_count=0, IDLE.
- MAX_FRAMES=3, no frame_last: after frame 3, overflow=1 and dec_start pulses; the next utterance's first frame has eng_first=1.
- KWS_ABORT_EN: abort during RUN at pair (5,1) → IDLE next cycle, frame_count=0, no dec_start; abort and eng_ack in the same cycle → abort wins.
